// File: rtl/serial_comparator.sv
// serial_comparator -- bit-serial unsigned magnitude comparator.
//
// Accepts an operand pair (A, B) on a valid/ready handshake, then walks the
// bits MSB-first, one bit per clock, latching the first difference into a
// gt/lt flag pair. The result (AeB/AgB/AlB) is held on a valid/ready output
// handshake until the consumer takes it. No overlap: a new pair is accepted
// only once the previous result has been taken.
//
// Optional feature (compile-time macro):
//   SERIAL_CMP_EARLY_EXIT_EN -- finish as soon as the first differing bit is
//   seen instead of always walking all WIDTH bits.
//
// Ports:
//   clk        single clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand pair presented
//   in_ready   block can accept a pair (IDLE only)
//   A, B       unsigned operands, WIDTH bits
//   out_valid  result presented (DONE only)
//   out_ready  consumer takes the result
//   AeB/AgB/AlB  A==B / A>B / A<B, all zero unless out_valid
//   busy       high whenever not IDLE
module serial_comparator #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             AeB,
  output logic             AgB,
  output logic             AlB,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  logic bit_gt, bit_lt, last_bit, finish;

  // Operands shift left, so the bit under test is always the MSB.
  assign bit_gt   = a_q[WIDTH-1] & ~b_q[WIDTH-1];
  assign bit_lt   = ~a_q[WIDTH-1] & b_q[WIDTH-1];
  assign last_bit = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    lt_d    = lt_q;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          cnt_d   = CW'(WIDTH - 1);
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Only the first (most significant) difference decides the result.
        if (!gt_q && !lt_q) begin
          gt_d = bit_gt;
          lt_d = bit_lt;
        end
        a_d = {a_q[WIDTH-2:0], 1'b0};
        b_d = {b_q[WIDTH-2:0], 1'b0};
        if (!last_bit) cnt_d = cnt_q - 1'b1;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
        finish = last_bit | gt_d | lt_d;
`else
        finish = last_bit;
`endif
        if (finish) state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign AgB       = out_valid & gt_q;
  assign AlB       = out_valid & lt_q;
  assign AeB       = out_valid & ~gt_q & ~lt_q;

endmodule
